// File: rtl/regbank_pkg.sv
// ---------------------------------------------------------------------------
// regbank_pkg
// Shared defaults and types for the integer register bank and its busy
// scoreboard.
//
// Contents
//   RB_DATA_W   default register width in bits
//   RB_ADDR_W   default address width
//   RB_DEPTH    default number of registers (2**RB_ADDR_W)
//   reg_addr_t  register index at the default address width
//   reg_data_t  register contents at the default data width
// ---------------------------------------------------------------------------
package regbank_pkg;

  // Default geometry. The modules re-derive their own depth from their
  // parameters, so these only seed the parameter defaults.
  localparam int RB_DATA_W = 64;
  localparam int RB_ADDR_W = 5;
  localparam int RB_DEPTH  = 2 ** RB_ADDR_W;

  typedef logic [RB_ADDR_W-1:0] reg_addr_t;
  typedef logic [RB_DATA_W-1:0] reg_data_t;

endpackage : regbank_pkg

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Per-register busy tracking for reg_bank_sb. A register becomes busy when an
// instruction issues with it as destination and is released by its
// writeback. Also flags writebacks that land on a register nobody was
// waiting for.
//
// Ports
//   clk        in   clock, busy bits update on posedge
//   rst_n      in   async active-low reset, clears all busy bits
//   iss_en     in   issue strobe
//   iss_addr   in   destination register of the issuing instruction
//   wr_en      in   writeback strobe
//   wr_addr    in   writeback destination
//   rd_addr1   in   read port 1 address
//   rd_addr2   in   read port 2 address
//   hit1       in   read port 1 is being served by the bypass this cycle
//   hit2       in   read port 2 is being served by the bypass this cycle
//   rd_busy1   out  register at rd_addr1 still waits for its producer
//   rd_busy2   out  register at rd_addr2 still waits for its producer
//   wb_orphan  out  registered pulse: last cycle's writeback hit a free reg
// ---------------------------------------------------------------------------
module reg_scoreboard
  import regbank_pkg::*;
#(
  parameter int ADDR_W   = RB_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              hit1,
  input  logic              hit2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic              wb_orphan
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic             iss_ok;
  logic             wr_zero;

  // Next busy vector. The clear from writeback is applied first and the set
  // from issue second, so when both strobes target the same register the
  // newer producer stays outstanding. Register 0 can never be busy when it
  // is hardwired to zero.
  always_comb begin
    wr_zero   = ZERO_REG && (wr_addr == '0);
    iss_ok    = iss_en && !(ZERO_REG && (iss_addr == '0));
    busy_next = busy;
    if (wr_en) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (iss_ok) begin
      busy_next[iss_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_next[0] = 1'b0;
    end
  end

  // Busy state and the orphan pulse. The orphan test uses the busy bit as it
  // stood before this edge, i.e. what the writeback actually found.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      wb_orphan <= 1'b0;
    end else begin
      busy      <= busy_next;
      wb_orphan <= wr_en && !busy[wr_addr] && !wr_zero;
    end
  end

  // A register whose value is being forwarded this cycle is usable now, so
  // a bypass hit masks its busy bit.
  always_comb begin
    rd_busy1 = busy[rd_addr1] && !hit1;
    rd_busy2 = busy[rd_addr2] && !hit2;
  end

endmodule : reg_scoreboard

// File: rtl/reg_bank_sb.sv
// ---------------------------------------------------------------------------
// reg_bank_sb
// Integer register file with two combinational read ports, one synchronous
// write port, optional write-to-read bypass and an optional hardwired zero
// register, plus a busy scoreboard (reg_scoreboard) for issue/writeback
// tracking. Sits between decode (reads + issue) and writeback.
//
// Parameters
//   DATA_W      register width
//   ADDR_W      address width, 2**ADDR_W registers
//   ZERO_REG    register 0 reads 0, ignores writes, is never busy
//   BYPASS      same-cycle write data is forwarded to matching read ports
//   INIT_INDEX  reset loads reg[i] = i, otherwise 0
//
// Ports
//   clk        in   clock
//   rst_n      in   async active-low reset
//   rd_addr1   in   read port 1 address
//   rd_addr2   in   read port 2 address
//   rd_data1   out  read port 1 data (combinational)
//   rd_data2   out  read port 2 data (combinational)
//   rd_busy1   out  reg at rd_addr1 has an outstanding producer
//   rd_busy2   out  reg at rd_addr2 has an outstanding producer
//   wr_en      in   writeback strobe
//   wr_addr    in   writeback address
//   wr_data    in   writeback data
//   iss_en     in   issue strobe, marks iss_addr busy
//   iss_addr   in   destination of issuing instruction
//   wb_orphan  out  registered pulse: previous write hit a non-busy register
// ---------------------------------------------------------------------------
module reg_bank_sb
  import regbank_pkg::*;
#(
  parameter int DATA_W     = RB_DATA_W,
  parameter int ADDR_W     = RB_ADDR_W,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1,
  parameter bit INIT_INDEX = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              wb_orphan
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_ok;
  logic              hit1;
  logic              hit2;

  // A write to the hardwired zero register is dropped entirely: it neither
  // updates storage nor feeds the bypass.
  always_comb begin
    wr_ok = wr_en && !(ZERO_REG && (wr_addr == '0));
    hit1  = BYPASS && wr_ok && (wr_addr == rd_addr1);
    hit2  = BYPASS && wr_ok && (wr_addr == rd_addr2);
  end

  // Storage. Reset contents are either the register index (truncated or
  // zero-extended to the data width) or all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= INIT_INDEX ? DATA_W'(i) : '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: zero-register masking has priority, then the bypass, then
  // the stored value. Both ports are fully independent.
  always_comb begin
    if (ZERO_REG && (rd_addr1 == '0)) begin
      rd_data1 = '0;
    end else if (hit1) begin
      rd_data1 = wr_data;
    end else begin
      rd_data1 = regs[rd_addr1];
    end

    if (ZERO_REG && (rd_addr2 == '0)) begin
      rd_data2 = '0;
    end else if (hit2) begin
      rd_data2 = wr_data;
    end else begin
      rd_data2 = regs[rd_addr2];
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .hit1      (hit1),
    .hit2      (hit2),
    .rd_busy1  (rd_busy1),
    .rd_busy2  (rd_busy2),
    .wb_orphan (wb_orphan)
  );

endmodule : reg_bank_sb

// File: tb/tb_reg_bank_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_sb
// Two register banks side by side: A uses the default configuration
// (64-bit, 32 regs, zero reg, bypass, index init), B uses 32-bit, 16 regs,
// no zero reg, no bypass, zero init. Both see the same stimulus (addresses
// and data folded to B's size). Expected outputs come from an array model
// and are queued per cycle; a monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_reg_bank_sb;
  import regbank_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Bank A (default parameters)
  logic [RB_ADDR_W-1:0] a_rd_addr1, a_rd_addr2, a_wr_addr, a_iss_addr;
  logic [RB_DATA_W-1:0] a_rd_data1, a_rd_data2, a_wr_data;
  logic                 a_rd_busy1, a_rd_busy2, a_wr_en, a_iss_en, a_wb_orphan;

  // Bank B (32-bit, 16 regs)
  logic [3:0]  b_rd_addr1, b_rd_addr2, b_wr_addr, b_iss_addr;
  logic [31:0] b_rd_data1, b_rd_data2, b_wr_data;
  logic        b_rd_busy1, b_rd_busy2, b_wr_en, b_iss_en, b_wb_orphan;

  reg_bank_sb u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(a_rd_addr1), .rd_addr2(a_rd_addr2),
    .rd_data1(a_rd_data1), .rd_data2(a_rd_data2),
    .rd_busy1(a_rd_busy1), .rd_busy2(a_rd_busy2),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .iss_en(a_iss_en), .iss_addr(a_iss_addr), .wb_orphan(a_wb_orphan)
  );

  reg_bank_sb #(
    .DATA_W(32), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b0), .INIT_INDEX(1'b0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2),
    .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
    .rd_busy1(b_rd_busy1), .rd_busy2(b_rd_busy2),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .iss_en(b_iss_en), .iss_addr(b_iss_addr), .wb_orphan(b_wb_orphan)
  );

  typedef struct packed {
    logic [63:0] d1;
    logic [63:0] d2;
    logic        b1;
    logic        b2;
    logic        orph;
  } exp_t;

  typedef struct {
    bit          wr_en;
    int          wa;
    logic [63:0] wd;
    bit          iss;
    int          ia;
    int          ra1;
    int          ra2;
  } stim_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  // Reference model: plain arrays holding what each register should contain,
  // whether it is awaiting a writeback, and the orphan flag currently shown.
  logic [63:0] m_reg  [2][32];
  bit          m_busy [2][32];
  bit          m_orph [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Per-bank configuration.
  function automatic int nregs(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic logic [63:0] dmask(input int k);
    return (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic bit has_zero(input int k);
    return k == 0;
  endfunction

  function automatic bit has_bypass(input int k);
    return k == 0;
  endfunction

  function automatic bit init_idx(input int k);
    return k == 0;
  endfunction

  function automatic stim_t mk(input bit we, input int wa, input logic [63:0] wd,
                               input bit iss, input int ia, input int ra1, input int ra2);
    stim_t s;
    s.wr_en = we; s.wa = wa; s.wd = wd; s.iss = iss; s.ia = ia; s.ra1 = ra1; s.ra2 = ra2;
    return s;
  endfunction

  function automatic stim_t fit(input stim_t s, input int k);
    stim_t f;
    f     = s;
    f.wa  = s.wa  % nregs(k);
    f.ia  = s.ia  % nregs(k);
    f.ra1 = s.ra1 % nregs(k);
    f.ra2 = s.ra2 % nregs(k);
    f.wd  = s.wd & dmask(k);
    return f;
  endfunction

  task automatic modelReset(input int k);
    for (int i = 0; i < 32; i++) begin
      m_reg[k][i]  = init_idx(k) ? (64'(i) & dmask(k)) : 64'h0;
      m_busy[k][i] = 1'b0;
    end
    m_orph[k] = 1'b0;
  endtask

  function automatic bit dropped(input int k, input int a);
    return has_zero(k) && (a == 0);
  endfunction

  function automatic bit fwd(input int k, input stim_t s, input int a);
    return has_bypass(k) && s.wr_en && (s.wa == a) && !dropped(k, s.wa);
  endfunction

  function automatic logic [63:0] expRead(input int k, input stim_t s, input int a);
    if (dropped(k, a)) return 64'h0;
    if (fwd(k, s, a))  return s.wd;
    return m_reg[k][a];
  endfunction

  // Drive one cycle of inputs at the falling edge, queue what both banks
  // should show before the next rising edge, then advance the model past it.
  task automatic applyStimulus(input stim_t s, input bit rst);
    stim_t f;
    exp_t  e;
    bit    zw;
    @(negedge clk);
    rst_n = rst;
    f = fit(s, 0);
    a_wr_en = f.wr_en; a_wr_addr = 5'(f.wa); a_wr_data = f.wd;
    a_iss_en = f.iss;  a_iss_addr = 5'(f.ia);
    a_rd_addr1 = 5'(f.ra1); a_rd_addr2 = 5'(f.ra2);
    f = fit(s, 1);
    b_wr_en = f.wr_en; b_wr_addr = 4'(f.wa); b_wr_data = f.wd[31:0];
    b_iss_en = f.iss;  b_iss_addr = 4'(f.ia);
    b_rd_addr1 = 4'(f.ra1); b_rd_addr2 = 4'(f.ra2);

    for (int k = 0; k < 2; k++) begin
      f = fit(s, k);
      if (!rst) modelReset(k);
      e.d1   = expRead(k, f, f.ra1);
      e.d2   = expRead(k, f, f.ra2);
      e.b1   = m_busy[k][f.ra1] && !fwd(k, f, f.ra1);
      e.b2   = m_busy[k][f.ra2] && !fwd(k, f, f.ra2);
      e.orph = m_orph[k];
      if (k == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      if (rst) begin
        zw = dropped(k, f.wa);
        m_orph[k] = f.wr_en && !m_busy[k][f.wa] && !zw;
        if (f.wr_en && !zw) m_reg[k][f.wa] = f.wd;
        if (f.wr_en) m_busy[k][f.wa] = 1'b0;
        if (f.iss && !dropped(k, f.ia)) m_busy[k][f.ia] = 1'b1;
      end
    end
  endtask

  task automatic cmp(input string name, input int k, input logic [63:0] act,
                     input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s bank%0d @%0t: got %h, expected %h", name, k, $time, act, expv);
    end
  endtask

  task automatic checkOutput(input int k, input exp_t e);
    if (k == 0) begin
      cmp("rd_data1", k, a_rd_data1, e.d1);
      cmp("rd_data2", k, a_rd_data2, e.d2);
      cmp("rd_busy1", k, 64'(a_rd_busy1), 64'(e.b1));
      cmp("rd_busy2", k, 64'(a_rd_busy2), 64'(e.b2));
      cmp("wb_orphan", k, 64'(a_wb_orphan), 64'(e.orph));
    end else begin
      cmp("rd_data1", k, {32'h0, b_rd_data1}, e.d1);
      cmp("rd_data2", k, {32'h0, b_rd_data2}, e.d2);
      cmp("rd_busy1", k, 64'(b_rd_busy1), 64'(e.b1));
      cmp("rd_busy2", k, 64'(b_rd_busy2), 64'(e.b2));
      cmp("wb_orphan", k, 64'(b_wb_orphan), 64'(e.orph));
    end
  endtask

  // Monitor: the combinational outputs settle after the falling-edge drive,
  // so sample a few time units later, well before the rising edge.
  always @(negedge clk) begin
    #3;
    if (exp_q0.size() > 0) checkOutput(0, exp_q0.pop_front());
    if (exp_q1.size() > 0) checkOutput(1, exp_q1.pop_front());
  end

  stim_t idle;
  stim_t rs;
  int    guard;

  initial begin
    rst_n = 1'b1;
    a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_iss_en = 0; a_iss_addr = 0;
    a_rd_addr1 = 0; a_rd_addr2 = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_iss_en = 0; b_iss_addr = 0;
    b_rd_addr1 = 0; b_rd_addr2 = 0;
    idle = mk(0, 0, 64'h0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    modelReset(0);
    modelReset(1);
    $display("[TB] starting");

    // Reset contents, with traffic ignored while reset is held
    applyStimulus(mk(0, 0, 64'h0, 0, 0, 7, 0), 1'b0);
    applyStimulus(mk(1, 3, 64'hAA, 1, 4, 7, 0), 1'b0);
    applyStimulus(mk(0, 0, 64'h0, 0, 0, 7, 3), 1'b1);

    // Write then read, with and without bypass
    applyStimulus(mk(1, 5, 64'hDEAD_BEEF, 0, 0, 1, 5), 1'b1);
    applyStimulus(mk(0, 0, 64'h0, 0, 0, 1, 5), 1'b1);

    // Zero register write and issue
    applyStimulus(mk(1, 0, 64'h1234, 1, 0, 0, 0), 1'b1);
    applyStimulus(mk(0, 0, 64'h0, 0, 0, 0, 0), 1'b1);

    // Scoreboard set/clear and same-cycle priority
    applyStimulus(mk(0, 0, 64'h0, 1, 9, 9, 9), 1'b1);
    applyStimulus(mk(0, 0, 64'h0, 0, 0, 9, 2), 1'b1);
    applyStimulus(mk(1, 9, 64'h55, 0, 0, 9, 9), 1'b1);
    applyStimulus(mk(0, 0, 64'h0, 0, 0, 9, 9), 1'b1);
    applyStimulus(mk(1, 9, 64'h66, 1, 9, 9, 9), 1'b1);
    applyStimulus(mk(0, 0, 64'h0, 0, 0, 9, 9), 1'b1);
    applyStimulus(mk(0, 0, 64'h0, 1, 9, 9, 9), 1'b1);
    applyStimulus(mk(1, 9, 64'h77, 0, 0, 3, 9), 1'b1);
    applyStimulus(mk(0, 0, 64'h0, 0, 0, 9, 9), 1'b1);

    // Orphan writeback pulse
    applyStimulus(mk(1, 12, 64'hC0FFEE, 0, 0, 12, 1), 1'b1);
    applyStimulus(mk(0, 0, 64'h0, 0, 0, 12, 12), 1'b1);
    applyStimulus(mk(0, 0, 64'h0, 0, 0, 12, 12), 1'b1);

    // Random traffic with occasional reset mid-stream
    for (int n = 0; n < 400; n++) begin
      rs.wr_en = ($urandom_range(0, 1) == 1);
      rs.wa    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      rs.wd    = {$urandom, $urandom};
      rs.iss   = ($urandom_range(0, 2) == 0);
      rs.ia    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      rs.ra1   = ($urandom_range(0, 3) == 0) ? rs.wa : $urandom_range(0, 31);
      rs.ra2   = ($urandom_range(0, 3) == 0) ? rs.ia : $urandom_range(0, 31);
      applyStimulus(rs, $urandom_range(0, 59) != 0);
    end

    // Fresh reset contents across every register, then walking ones
    applyStimulus(idle, 1'b0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(mk(0, 0, 64'h0, 0, 0, i, 31 - i), 1'b1);
    end
    for (int b = 0; b < 64; b++) begin
      applyStimulus(mk(1, b % 32, 64'd1 << b, 0, 0, 1, 2), 1'b1);
      applyStimulus(mk(0, 0, 64'h0, 0, 0, b % 32, b % 16), 1'b1);
    end

    // Let the monitor drain, bounded
    guard = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    n_checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d/%0d entries left, expected 0/0",
               exp_q0.size(), exp_q1.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_bank_sb
